tdm_demux_1x8: RTL and testbench

//  Receive end of the 8-to-1 bit-select path. A serial stream carries one bit
//  per slot in an 8-slot time-division frame; this block turns it back into
//  an 8-bit parallel word. Bit k of the word is the bit received in slot k.
//  A slot counter drives the select, so this acts as a registered 1-to-8 demux.

---
 rtl/tdm_demux_1x8.sv | 77 +++++++
 tb/tb_tdm_demux_1x8.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1x8.sv
// Purpose: rebuild 8-bit parallel frame words from a 1-bit-per-slot TDM serial stream.
// Latency: out/out_valid update on the same edge that samples the last slot bit.
// Backpressure: none; din_valid gaps simply hold state, and there is no ready to the link.
module tdm_demux_1x8 #(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  out,
  output logic             out_valid,
  output logic             frame_err
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);

  state_t          state;
  // The last slot goes straight to out, so only slots 0..N_CH-2 need shadowing.
  logic [N_CH-2:0] shadow;

  // Slot collection FSM: shadow fill, frame completion, and early-sync discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      shadow    <= '0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      if (din_valid) begin
        case (state)
          IDLE: begin
            // Bits arriving before a sync are dropped silently.
            if (frame_sync) begin
              shadow[0] <= din;
              sel       <= SEL_W'(1);
              state     <= COLLECT;
            end
          end
          COLLECT: begin
            if (frame_sync) begin
              // Sync mid-frame: drop the partial word and restart at slot 0.
              frame_err <= 1'b1;
              shadow[0] <= din;
              sel       <= SEL_W'(1);
            end else if (sel == LAST_SLOT) begin
              out       <= {din, shadow};
              out_valid <= 1'b1;
              sel       <= '0;
              state     <= IDLE;
            end else begin
              shadow[sel] <= din;
              sel         <= sel + SEL_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            sel   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1x8.sv
module tb_tdm_demux_1x8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [2:0] sel;
  logic [7:0] out;
  logic       out_valid;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pulse_cyc = 0;
  int prev_pulse = 0;

  tdm_demux_1x8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .sel        (sel),
    .out        (out),
    .out_valid  (out_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Free-running cycle count, used to measure pulse spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, step past the rising edge, settle for sampling.
  task automatic drive(input logic d, input logic v, input logic s);
    din        = d;
    din_valid  = v;
    frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      check("idle_pulse", {30'd0, out_valid, frame_err}, 32'd0);
    end
  endtask

  // Full frame, LSB first, sync on slot 0, `gap` invalid cycles after each slot
  // except the last. Leaves din_valid asserted so frames can run back to back.
  task automatic send_frame(input logic [7:0] w, input int gap, input string tag);
    logic [2:0] exp_sel;
    for (int k = 0; k < 8; k++) begin
      drive(w[k], 1'b1, k == 0);
      exp_sel = (k == 7) ? 3'd0 : 3'(k + 1);
      check({tag, "_sel"}, sel, exp_sel);
      check({tag, "_err"}, frame_err, 1'b0);
      if (k < 7) begin
        check({tag, "_vld_early"}, out_valid, 1'b0);
        for (int g = 0; g < gap; g++) begin
          drive(1'b1, 1'b0, 1'b1);
          check({tag, "_gap_sel"}, sel, exp_sel);
          check({tag, "_gap_vld"}, out_valid, 1'b0);
        end
      end else begin
        check({tag, "_vld"}, out_valid, 1'b1);
        check({tag, "_out"}, out, w);
        prev_pulse = pulse_cyc;
        pulse_cyc  = cyc;
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 8'h00);
    check("rst_sel", sel, 3'd0);
    check("rst_pulses", {30'd0, out_valid, frame_err}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // 1: contiguous frame
    send_frame(8'hA5, 0, "t1");
    idle(1);
    check("t1_hold_out", out, 8'hA5);

    // 2: two-cycle gaps between slots
    send_frame(8'h3C, 2, "t2");
    idle(2);
    check("t2_hold_out", out, 8'h3C);

    // 3: back-to-back frames
    send_frame(8'h01, 0, "t3a");
    send_frame(8'h80, 0, "t3b");
    check("t3_spacing", pulse_cyc - prev_pulse, 8);
    idle(1);

    // 4: resync after 4 bits discards the partial frame
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check("t4_sel_partial", sel, 3'd4);
    drive(1'b1, 1'b1, 1'b1);
    check("t4_err", frame_err, 1'b1);
    check("t4_vld_at_err", out_valid, 1'b0);
    check("t4_out_kept", out, 8'h80);
    check("t4_sel_resync", sel, 3'd1);
    for (int k = 1; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      check("t4_err_clear", frame_err, 1'b0);
    end
    check("t4_vld", out_valid, 1'b1);
    check("t4_out", out, 8'hFF);
    idle(1);

    // 5: reset mid-frame
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, k == 0);
    check("t5_sel_pre", sel, 3'd5);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out", out, 8'h00);
    check("t5_rst_sel", sel, 3'd0);
    drive(1'b1, 1'b1, 1'b0);
    check("t5_rst_hold_out", out, 8'h00);
    check("t5_rst_hold_sel", sel, 3'd0);
    check("t5_rst_pulses", {30'd0, out_valid, frame_err}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    check("t5_post_rel_out", out, 8'h00);
    send_frame(8'h5A, 0, "t5");
    idle(1);

    // 6: valid bits with no sync while idle are dropped
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      check("t6_sel", sel, 3'd0);
      check("t6_pulses", {30'd0, out_valid, frame_err}, 32'd0);
    end
    check("t6_out", out, 8'h5A);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
